// File: rtl/gf2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf2_pkg
// Description : Shared GF(2) helpers: count-width function, solver state
//               encoding, popcount and parity.
// Revision    : 1.0 - initial release
// ============================================================================
package gf2_pkg;

    // Solver sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_ENUM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width needed to hold the values 0..n, never less than one bit
    function automatic int clog2p1(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Number of set bits in a vector (callers zero-extend to 32 bits)
    function automatic int popcount(input logic [31:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

    // XOR reduction of a vector
    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage : gf2_pkg
`default_nettype wire

// File: rtl/gf2_pdep.sv
`default_nettype none
// ============================================================================
// Module      : gf2_pdep
// Description : Combinational parallel bit deposit. Bit j of src lands in the
//               position of the j-th set bit of mask; other outputs are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_pdep #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] dep
);

    // Walk the mask LSB first, consuming source bits in order
    always_comb begin
        int j;
        j   = 0;
        dep = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                dep[i] = src[j];
                j      = j + 1;
            end
        end
    end

endmodule : gf2_pdep
`default_nettype wire

// File: rtl/gf2_rref_solve.sv
`default_nettype none
// ============================================================================
// Module      : gf2_rref_solve
// Description : Takes a GF(2) augmented matrix in reduced row-echelon form,
//               checks consistency, enumerates every free-variable
//               assignment (one per cycle) and reports the solution with the
//               smallest Hamming weight (lowest enumeration index on ties).
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_rref_solve
    import gf2_pkg::*;
#(
    parameter int MAX_ROWS   = 4,
    parameter int MAX_COLS   = 7,
    parameter int MAX_VARS   = MAX_COLS - 1,
    parameter int MAX_ROWS_W = clog2p1(MAX_ROWS),
    parameter int MAX_COLS_W = clog2p1(MAX_COLS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [MAX_ROWS_W-1:0]              rows,
    input  logic [MAX_COLS_W-1:0]              cols,
    input  logic                               start,
    input  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  RREF,
    output logic                               ready,
    output logic                               solvable,
    output logic [MAX_VARS-1:0]                x_min,
    output logic [MAX_COLS_W-1:0]              weight_min
);

    // Enumeration counter is one bit wider than the variable count so that
    // the terminal value 2^MAX_VARS is representable without wrapping.
    localparam int K_W = MAX_VARS + 1;

    // ------------------------------------------------------------------
    // Registered job state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [MAX_ROWS_W-1:0]   r_rows;
    logic [MAX_ROWS_W-1:0]   r_row;
    logic [MAX_COLS_W-1:0]   r_cols;
    logic [MAX_COLS-1:0]     r_mat      [MAX_ROWS];
    logic [MAX_VARS-1:0]     r_pivot_mask;
    logic [MAX_VARS-1:0]     r_pivot_oh [MAX_ROWS];  // one-hot pivot column per row, zero if none
    logic                    r_incons;
    logic [K_W-1:0]          r_k;
    logic [MAX_VARS-1:0]     r_best_x;
    logic [MAX_COLS_W-1:0]   r_best_w;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [MAX_ROWS_W-1:0]   w_rows_eff;
    logic [MAX_VARS-1:0]     w_var_mask;
    logic [MAX_ROWS-1:0]     w_rhs;
    logic [MAX_VARS-1:0]     w_row_vars [MAX_ROWS];
    logic [MAX_VARS-1:0]     w_cur_vars;
    logic                    w_cur_rhs;
    logic [MAX_VARS-1:0]     w_cur_oh;
    logic                    w_scan_active;
    logic                    w_scan_last;
    logic [MAX_VARS-1:0]     w_free_mask;
    logic [MAX_COLS_W-1:0]   w_nfree;
    logic [K_W-1:0]          w_limit;
    logic [MAX_VARS-1:0]     w_free_vals;
    logic [MAX_VARS-1:0]     w_cand_x;
    logic [MAX_COLS_W-1:0]   w_cand_w;

    // Out-of-range row counts are clamped to the matrix height
    assign w_rows_eff = (rows > MAX_ROWS_W'(MAX_ROWS)) ? MAX_ROWS_W'(MAX_ROWS) : rows;

    // Active variable columns are 0..cols-2; cols<=1 leaves none
    always_comb begin
        w_var_mask = '0;
        for (int v = 0; v < MAX_VARS; v++) begin
            w_var_mask[v] = (MAX_COLS_W'(v + 1) < r_cols);
        end
    end

    // Per-row RHS bit (column cols-1) and masked variable coefficients
    always_comb begin
        for (int r = 0; r < MAX_ROWS; r++) begin
            w_rhs[r] = 1'b0;
            for (int c = 0; c < MAX_COLS; c++) begin
                if (MAX_COLS_W'(c + 1) == r_cols) begin
                    w_rhs[r] = r_mat[r][c];
                end
            end
            w_row_vars[r] = r_mat[r][MAX_VARS-1:0] & w_var_mask;
        end
    end

    // Row under inspection during SCAN and its lowest set variable bit
    always_comb begin
        w_cur_vars = '0;
        w_cur_rhs  = 1'b0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            if (MAX_ROWS_W'(r) == r_row) begin
                w_cur_vars = w_row_vars[r];
                w_cur_rhs  = w_rhs[r];
            end
        end
        w_cur_oh = w_cur_vars & (~w_cur_vars + MAX_VARS'(1));
    end

    assign w_scan_active = (r_rows != '0);
    assign w_scan_last   = !w_scan_active || (r_row == r_rows - MAX_ROWS_W'(1));

    // Free columns and the number of assignments to enumerate
    assign w_free_mask = ~r_pivot_mask & w_var_mask;
    assign w_nfree     = MAX_COLS_W'(popcount(32'(w_free_mask)));
    assign w_limit     = K_W'(1) << w_nfree;

    gf2_pdep #(
        .WIDTH (MAX_VARS)
    ) u_pdep (
        .src  (r_k[MAX_VARS-1:0]),
        .mask (w_free_mask),
        .dep  (w_free_vals)
    );

    // Back-substitute the current free assignment into every pivot row
    always_comb begin
        w_cand_x = w_free_vals;
        for (int r = 0; r < MAX_ROWS; r++) begin
            if (w_rhs[r] ^ parity(32'(w_row_vars[r] & w_free_vals))) begin
                w_cand_x = w_cand_x | r_pivot_oh[r];
            end
        end
        w_cand_w = MAX_COLS_W'(popcount(32'(w_cand_x)));
    end

    // Control FSM: capture, pivot scan, enumeration, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rows       <= '0;
            r_row        <= '0;
            r_cols       <= '0;
            r_pivot_mask <= '0;
            r_incons     <= 1'b0;
            r_k          <= '0;
            r_best_x     <= '0;
            r_best_w     <= '0;
            ready        <= 1'b0;
            solvable     <= 1'b0;
            x_min        <= '0;
            weight_min   <= '0;
            for (int r = 0; r < MAX_ROWS; r++) begin
                r_mat[r]      <= '0;
                r_pivot_oh[r] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_rows       <= w_rows_eff;
                        r_cols       <= cols;
                        r_row        <= '0;
                        r_pivot_mask <= '0;
                        r_incons     <= 1'b0;
                        ready        <= 1'b0;
                        r_state      <= ST_SCAN;
                        for (int r = 0; r < MAX_ROWS; r++) begin
                            r_mat[r]      <= RREF[r];
                            r_pivot_oh[r] <= '0;
                        end
                    end
                end

                ST_SCAN: begin
                    if (w_scan_active) begin
                        r_pivot_mask <= r_pivot_mask | w_cur_oh;
                        for (int r = 0; r < MAX_ROWS; r++) begin
                            if (MAX_ROWS_W'(r) == r_row) begin
                                r_pivot_oh[r] <= w_cur_oh;
                            end
                        end
                        if ((w_cur_vars == '0) && w_cur_rhs) begin
                            r_incons <= 1'b1;
                        end
                    end
                    if (w_scan_last) begin
                        r_k      <= '0;
                        r_best_x <= '0;
                        r_best_w <= '1;
                        r_state  <= ST_ENUM;
                    end else begin
                        r_row <= r_row + MAX_ROWS_W'(1);
                    end
                end

                ST_ENUM: begin
                    // First ENUM cycle resolves an inconsistent system
                    if (r_incons) begin
                        solvable   <= 1'b0;
                        x_min      <= '0;
                        weight_min <= '0;
                        ready      <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (r_k == w_limit) begin
                        solvable   <= 1'b1;
                        x_min      <= r_best_x;
                        weight_min <= r_best_w;
                        ready      <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        // Strictly lighter only, so ties keep the lowest k
                        if (w_cand_w < r_best_w) begin
                            r_best_x <= w_cand_x;
                            r_best_w <= w_cand_w;
                        end
                        r_k <= r_k + K_W'(1);
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : gf2_rref_solve
`default_nettype wire

// File: tb/tb_gf2_rref_solve.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf2_rref_solve
// Description : Self-checking bench for gf2_rref_solve. A brute-force
//               reference enumerates every variable vector and picks the
//               lightest solution (ties broken by free-variable index).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2_rref_solve;

    typedef logic [3:0][6:0] mat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rows;
    logic [2:0] cols;
    logic       start;
    mat_t       RREF;
    logic       ready;
    logic       solvable;
    logic [5:0] x_min;
    logic [2:0] weight_min;

    int n_asserts = 0;
    int n_fail    = 0;

    gf2_rref_solve dut (
        .clk        (clk),
        .rst        (rst),
        .rows       (rows),
        .cols       (cols),
        .start      (start),
        .RREF       (RREF),
        .ready      (ready),
        .solvable   (solvable),
        .x_min      (x_min),
        .weight_min (weight_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Brute-force reference: scan every x, keep lightest, tie -> smallest
    // free-variable index (bits of x gathered from the free columns).
    function automatic void model(input logic [2:0] rw, input logic [2:0] cl, input mat_t m,
                                  output logic esol, output logic [5:0] ex,
                                  output logic [2:0] ew, output int elat);
        int nv, re, vm, piv, vars, free, nf, bw, bk, bx, w, k, j, rr, c1;
        logic ok, rhs;
        nv  = (cl > 1) ? int'(cl) - 1 : 0;
        re  = (rw > 4) ? 4 : int'(rw);
        vm  = (1 << nv) - 1;
        c1  = int'(cl) - 1;
        piv = 0;
        for (int r = 0; r < re; r++) begin
            vars = int'(m[r]) & vm;
            if (vars != 0) piv = piv | (vars & -vars);
        end
        free = vm & ~piv;
        nf   = $countones(free);
        bw = 99; bk = 0; bx = 0;
        for (int x = 0; x < (1 << nv); x++) begin
            ok = 1'b1;
            for (int r = 0; r < re; r++) begin
                rhs = (cl > 0) ? m[r][c1] : 1'b0;
                if ((^(int'(m[r]) & vm & x)) != rhs) ok = 1'b0;
            end
            if (ok) begin
                w = $countones(x);
                k = 0; j = 0;
                for (int v = 0; v < nv; v++) begin
                    if (free[v]) begin
                        k = k | (((x >> v) & 1) << j);
                        j++;
                    end
                end
                if (w < bw || (w == bw && k < bk)) begin
                    bw = w; bk = k; bx = x;
                end
            end
        end
        esol = (bw != 99);
        ex   = esol ? 6'(bx) : 6'd0;
        ew   = esol ? 3'(bw) : 3'd0;
        rr   = (re < 1) ? 1 : re;
        elat = esol ? (1 + rr + (1 << nf) + 1) : (1 + rr + 1);
    endfunction

    // Launch one job, optionally pulse start at cycle 'poke', check results
    task automatic run_job(input logic [2:0] rw, input logic [2:0] cl, input mat_t m,
                           input string tag, input int poke);
        logic       esol;
        logic [5:0] ex;
        logic [2:0] ew;
        int         elat, cyc;
        model(rw, cl, m, esol, ex, ew, elat);
        @(negedge clk);
        rows = rw; cols = cl; RREF = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rows  = 3'($urandom);
        cols  = 3'($urandom);
        RREF  = mat_t'({$urandom, $urandom});
        cyc   = 1;
        check({tag, "_ready_low"}, 32'(ready), 32'd0);
        while (!ready && cyc < 400) begin
            start = (poke != 0 && cyc == poke);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"},  32'(cyc),        32'(elat));
        check({tag, "_solvable"}, 32'(solvable),   32'(esol));
        check({tag, "_x_min"},    32'(x_min),      32'(ex));
        check({tag, "_weight"},   32'(weight_min), 32'(ew));
        @(posedge clk); #1;
        check({tag, "_hold"},     32'({ready, x_min}), 32'({1'b1, ex}));
    endtask

    initial begin
        mat_t m;
        logic [2:0] rw, cl;
        int nv, np, pm, pi, lim;

        rst = 1'b1; start = 1'b0; rows = '0; cols = '0; RREF = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",    32'(ready),      32'd0);
        check("reset_solvable", 32'(solvable),   32'd0);
        check("reset_x_min",    32'(x_min),      32'd0);
        check("reset_weight",   32'(weight_min), 32'd0);
        rst = 1'b0;

        // Directed cases
        m = '0; m[0] = 7'b101; m[1] = 7'b010;
        run_job(3'd2, 3'd3, m, "unique", 0);
        m = '0; m[0] = 7'b100;
        run_job(3'd1, 3'd3, m, "incons", 0);
        m = '0; m[0] = 7'b1101; m[1] = 7'b1110;
        run_job(3'd2, 3'd4, m, "one_free", 0);
        m = mat_t'({$urandom, $urandom});
        run_job(3'd0, 3'd7, m, "all_free", 0);
        m = '0; m[0] = 7'b111;
        run_job(3'd1, 3'd3, m, "tie", 0);
        m = '0; m[0] = 7'b1000101; m[1] = 7'b1001010;
        run_job(3'd2, 3'd7, m, "start_in_enum", 12);
        m = '0; m[0] = 7'b1;
        run_job(3'd1, 3'd1, m, "no_vars", 0);

        // Reset in the middle of enumeration
        m = '0; m[0] = 7'b101; m[1] = 7'b010;
        run_job(3'd2, 3'd3, m, "pre_reset", 0);
        @(negedge clk);
        rows = 3'd0; cols = 3'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready",    32'(ready),      32'd0);
        check("midrst_solvable", 32'(solvable),   32'd0);
        check("midrst_x_min",    32'(x_min),      32'd0);
        check("midrst_weight",   32'(weight_min), 32'd0);
        repeat (80) @(posedge clk);
        #1;
        check("midrst_idle", 32'(ready), 32'd0);
        m = '0; m[0] = 7'b1101; m[1] = 7'b1110;
        run_job(3'd2, 3'd4, m, "post_reset", 0);

        // Randomized valid RREF matrices, garbage outside the active area
        for (int t = 0; t < 40; t++) begin
            m  = mat_t'({$urandom, $urandom});
            nv = $urandom_range(0, 6);
            cl = (nv == 0) ? 3'($urandom_range(0, 1)) : 3'(nv + 1);
            rw = 3'($urandom_range(0, 4));
            for (int r = 0; r < 4; r++) begin
                if (r < int'(rw)) begin
                    for (int c = 0; c < int'(cl); c++) m[r][c] = 1'b0;
                end
            end
            lim = (int'(rw) < nv) ? int'(rw) : nv;
            np  = $urandom_range(0, lim);
            pm  = 0;
            while ($countones(pm) < np) pm = pm | (1 << $urandom_range(0, nv - 1));
            pi = 0;
            for (int c = 0; c < nv; c++) begin
                if (pm[c]) begin
                    m[pi][c] = 1'b1;
                    for (int d = c + 1; d < nv; d++) begin
                        if (!pm[d]) m[pi][d] = 1'($urandom);
                    end
                    m[pi][nv] = 1'($urandom);
                    pi++;
                end
            end
            for (int r = np; r < int'(rw); r++) begin
                if (cl > 0) m[r][int'(cl) - 1] = ($urandom_range(0, 3) == 0);
            end
            run_job(rw, cl, m, "random", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_gf2_rref_solve
`default_nettype wire
